// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the fetch stage and the decode-side
// control/hazard blocks.
//   NOP_INST         canonical bubble instruction (addi x0,x0,0)
//   DEFAULT_RESET_PC default program counter after reset
//   fetch_state_t    fetch FSM states
package fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clock, reset   rising-edge clock, async active-high reset (to a bubble)
//   load           capture inst/pc as a valid instruction
//   bubble         capture NOP_INST with pc, marked invalid
//   (neither)      hold current contents
//   inst, pc       incoming instruction word and its PC
//   if_inst, if_pc, if_valid  registered outputs towards decode
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_inst  <= NOP_INST;
      if_pc    <= RESET_PC;
      if_valid <= 1'b0;
    end else if (bubble) begin
      // Bubble takes precedence so a flush can never let a wrong-path word through.
      if_inst  <= NOP_INST;
      if_pc    <= pc;
      if_valid <= 1'b0;
    end else if (load) begin
      if_inst  <= inst;
      if_pc    <= pc;
      if_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage.
//   clock, reset       rising-edge clock, async active-high reset
//   imem_addr          current PC (combinational from PC register)
//   imem_data          instruction at imem_addr, same-cycle read
//   stall              hold PC, IF/ID and fetch_count
//   redirect/_pc       taken branch/jump from execute, with target
//   halt_req           ECALL seen by decode; drain pipeline then halt
//   if_id_inst/_pc     registered instruction and its PC for decode
//   if_id_valid        qualifier: decode may act on if_id_inst only when 1;
//                      when 0 the word is NOP_INST and must be treated as a
//                      bubble. There is no back-pressure from decode other
//                      than stall; each edge presents a new IF/ID word.
//   misaligned         sticky flag: some redirect target had bits [1:0] != 0
//   halted             high in HALTED
//   fetch_count        valid instructions loaded into IF/ID (wraps)
//   fsm_state          current FSM state, for observation
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic         clock,
  input  logic         reset,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_data,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         halt_req,
  output logic [31:0]  if_id_inst,
  output logic [31:0]  if_id_pc,
  output logic         if_id_valid,
  output logic         misaligned,
  output logic         halted,
  output logic [31:0]  fetch_count,
  output fetch_state_t fsm_state
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [31:0]      fetch_cnt_q, fetch_cnt_d;
  logic             misaligned_q, misaligned_d;
  logic             ifid_load, ifid_bubble;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      // Counter was loaded with DRAIN_CYCLES-1, so DRAIN lasts DRAIN_CYCLES edges.
      DRAIN:   if (drain_cnt_q == '0) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Output / datapath control
  always_comb begin
    pc_d         = pc_q;
    drain_cnt_d  = drain_cnt_q;
    fetch_cnt_d  = fetch_cnt_q;
    misaligned_d = misaligned_q;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          ifid_bubble = 1'b1;
          drain_cnt_d = DRAIN_LOAD;
        end else if (redirect) begin
          // Low bits are dropped; the flag records that the target was bad.
          pc_d        = {redirect_pc[31:2], 2'b00};
          ifid_bubble = 1'b1;
          if (redirect_pc[1:0] != 2'b00) misaligned_d = 1'b1;
        end else if (!stall) begin
          ifid_load   = 1'b1;
          pc_d        = pc_q + 32'd4;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      DRAIN: begin
        ifid_bubble = 1'b1;
        if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - 1'b1;
      end
      default: ifid_bubble = 1'b1;  // HALTED: keep refreshing the same bubble
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      drain_cnt_q  <= '0;
      fetch_cnt_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      drain_cnt_q  <= drain_cnt_d;
      fetch_cnt_q  <= fetch_cnt_d;
      misaligned_q <= misaligned_d;
    end
  end

  if_id_reg #(.RESET_PC(RESET_PC)) u_if_id (
    .clock    (clock),
    .reset    (reset),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .inst     (imem_data),
    .pc       (pc_q),
    .if_inst  (if_id_inst),
    .if_pc    (if_id_pc),
    .if_valid (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign misaligned  = misaligned_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = fetch_cnt_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0100_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0]  imem_addr, imem_data, redirect_pc;
  logic         stall, redirect, halt_req;
  logic [31:0]  if_id_inst, if_id_pc, fetch_count;
  logic         if_id_valid, misaligned, halted;
  fetch_state_t fsm_state;

  int n_vec = 0;
  int n_err = 0;

  // Instruction memory model: each address returns a distinct word.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction
  assign imem_data = inst_of(imem_addr);

  fetch_stage #(.RESET_PC(RST_PC), .DRAIN_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .if_id_inst  (if_id_inst),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .misaligned  (misaligned),
    .halted      (halted),
    .fetch_count (fetch_count),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] inst,
                            input logic [31:0] pc, input logic valid);
    check_val({tag, "_inst"},  if_id_inst, inst);
    check_val({tag, "_pc"},    if_id_pc, pc);
    check_val({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, valid});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rpc, input logic h);
    stall = s; redirect = r; redirect_pc = rpc; halt_req = h;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_addr", imem_addr, RST_PC);
    check_ifid("rst", NOP, RST_PC, 1'b0);
    check_val("rst_mis", {31'b0, misaligned}, 32'd0);
    check_val("rst_halt", {31'b0, halted}, 32'd0);
    check_val("rst_fc", fetch_count, 32'd0);
    check_val("rst_st", {30'b0, fsm_state}, {30'b0, RUN});
    reset = 1'b0;

    // Free-running fetch
    step();
    check_ifid("f0", inst_of(32'h0100_0000), 32'h0100_0000, 1'b1);
    check_val("f0_addr", imem_addr, 32'h0100_0004);
    check_val("f0_fc", fetch_count, 32'd1);
    step();
    check_ifid("f1", inst_of(32'h0100_0004), 32'h0100_0004, 1'b1);
    check_val("f1_addr", imem_addr, 32'h0100_0008);
    check_val("f1_fc", fetch_count, 32'd2);

    // Two stall cycles at 0x0100_0008
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("stl_addr", imem_addr, 32'h0100_0008);
      check_ifid("stl", inst_of(32'h0100_0004), 32'h0100_0004, 1'b1);
      check_val("stl_fc", fetch_count, 32'd2);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check_ifid("f2", inst_of(32'h0100_0008), 32'h0100_0008, 1'b1);
    check_val("f2_addr", imem_addr, 32'h0100_000C);
    check_val("f2_fc", fetch_count, 32'd3);

    // Redirect with simultaneous stall: redirect wins
    drive(1'b1, 1'b1, 32'h0100_0040, 1'b0);
    step();
    check_ifid("rd", NOP, 32'h0100_000C, 1'b0);
    check_val("rd_addr", imem_addr, 32'h0100_0040);
    check_val("rd_fc", fetch_count, 32'd3);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check_ifid("rd_tgt", inst_of(32'h0100_0040), 32'h0100_0040, 1'b1);
    check_val("rd_tgt_addr", imem_addr, 32'h0100_0044);
    check_val("rd_tgt_fc", fetch_count, 32'd4);
    check_val("rd_mis", {31'b0, misaligned}, 32'd0);

    // Misaligned redirect, then a clean one: flag sticks
    drive(1'b0, 1'b1, 32'h0100_0042, 1'b0);
    step();
    check_val("mis_addr", imem_addr, 32'h0100_0040);
    check_val("mis_flag", {31'b0, misaligned}, 32'd1);
    check_ifid("mis", NOP, 32'h0100_0044, 1'b0);
    drive(1'b0, 1'b1, 32'h0100_0080, 1'b0);
    step();
    check_val("mis2_addr", imem_addr, 32'h0100_0080);
    check_val("mis2_flag", {31'b0, misaligned}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check_ifid("f80", inst_of(32'h0100_0080), 32'h0100_0080, 1'b1);
    check_val("f80_fc", fetch_count, 32'd5);

    // halt_req with redirect: redirect ignored, HALTED four edges later
    drive(1'b0, 1'b1, 32'h0100_0200, 1'b1);
    step();
    check_ifid("h0", NOP, 32'h0100_0084, 1'b0);
    check_val("h0_addr", imem_addr, 32'h0100_0084);
    check_val("h0_halt", {31'b0, halted}, 32'd0);
    check_val("h0_st", {30'b0, fsm_state}, {30'b0, DRAIN});
    for (int i = 1; i < 4; i++) begin
      drive(i[0], 1'b1, 32'h0100_0300, 1'b0);
      step();
      check_val("dr_halt", {31'b0, halted}, 32'd0);
      check_val("dr_addr", imem_addr, 32'h0100_0084);
      check_ifid("dr", NOP, 32'h0100_0084, 1'b0);
    end
    step();
    check_val("hlt_halt", {31'b0, halted}, 32'd1);
    check_val("hlt_st", {30'b0, fsm_state}, {30'b0, HALTED});
    drive(1'b1, 1'b1, 32'h0100_0400, 1'b0);
    repeat (2) step();
    check_val("hlt2_halt", {31'b0, halted}, 32'd1);
    check_val("hlt2_addr", imem_addr, 32'h0100_0084);
    check_ifid("hlt2", NOP, 32'h0100_0084, 1'b0);
    check_val("hlt2_fc", fetch_count, 32'd5);

    // Reset mid-DRAIN takes effect without a clock edge
    reset = 1'b1;
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    step();
    step();
    check_val("r2_fc", fetch_count, 32'd2);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check_val("r2_st", {30'b0, fsm_state}, {30'b0, DRAIN});
    #2 reset = 1'b1;
    #1;
    check_val("ar_addr", imem_addr, RST_PC);
    check_ifid("ar", NOP, RST_PC, 1'b0);
    check_val("ar_fc", fetch_count, 32'd0);
    check_val("ar_halt", {31'b0, halted}, 32'd0);
    check_val("ar_st", {30'b0, fsm_state}, {30'b0, RUN});
    step();
    reset = 1'b0;
    step();
    check_ifid("ar_f0", inst_of(RST_PC), RST_PC, 1'b1);
    check_val("ar_f0_addr", imem_addr, 32'h0100_0004);
    check_val("ar_f0_fc", fetch_count, 32'd1);

    // PC wraps from 0xFFFF_FFFC to 0
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step();
    check_val("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check_ifid("wr", inst_of(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1);
    check_val("wr_addr1", imem_addr, 32'h0000_0000);
    check_val("wr_fc", fetch_count, 32'd2);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of the decode stage's control block. It owns the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register that decode consumes. It handles stalls from the hazard unit, redirects from execute (taken branch, JAL/JALR), and a halt/drain sequence triggered by ECALL. Bubbles are inserted as canonical NOPs, so decode always sees a legal instruction.

## Interface
- `RESET_PC`, default 32'h0100_0000: PC value loaded on reset.
- `DRAIN_CYCLES`, default 4: cycles spent in DRAIN before HALTED (covers ID..WB).
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `imem_addr`  out  32: current PC, combinational from the PC register.
- `imem_data`  in  32: instruction at `imem_addr`, combinational (same-cycle) read.
- `stall`  in  1: hold PC and IF/ID (load-use hazard).
- `redirect`  in  1: execute resolved a taken branch or jump.
- `redirect_pc`  in  32: target PC, valid while `redirect`=1.
- `halt_req`  in  1: decode saw ECALL; begin drain.
- `if_id_inst`  out  32: registered instruction for decode.
- `if_id_pc`  out  32: registered PC of `if_id_inst`.
- `if_id_valid`  out  1: 1 = real instruction, 0 = bubble.
- `misaligned`  out  1: sticky; set if a redirect target had bits [1:0] ≠ 0.
- `halted`  out  1: high in the HALTED state.
- `fetch_count`  out  32: number of valid instructions loaded into IF/ID.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- RUN priority, highest first: halt_req > redirect > stall > normal.
  - halt_req: IF/ID loads bubble, PC holds, go to DRAIN, drain counter loads DRAIN_CYCLES-1.
  - redirect: PC <= {redirect_pc[31:2],2'b00}; IF/ID loads bubble (this flushes the wrong-path instruction). If redirect_pc[1:0] ≠ 0, set `misaligned`. Redirect overrides a simultaneous stall.
  - stall: PC, IF/ID and fetch_count all hold.
  - normal: IF/ID <= {imem_data, PC, valid=1}; PC <= PC+4 (mod 2^32, wraps silently); fetch_count += 1 (wraps).
- A bubble is if_id_inst=32'h0000_0013 (addi x0,x0,0), if_id_pc=PC at that cycle, and if_id_valid=0.
- DRAIN: IF/ID loads bubbles; PC, stall and redirect are ignored. The counter decrements each cycle; at 0, go to HALTED.
- HALTED: IF/ID holds a bubble, PC frozen, `halted`=1. Only reset exits.
- `misaligned` clears only on reset.

## Timing
- Reset values: PC=RESET_PC, if_id_inst=32'h0000_0013, if_id_pc=RESET_PC, if_id_valid=0, misaligned=0, halted=0, fetch_count=0, state=RUN.
- Reset assertion mid-operation takes effect immediately (asynchronous). Fetch restarts at RESET_PC on the first rising edge after deassertion.
- Fetch latency: instruction at PC appears on IF/ID one cycle after `imem_addr`=PC.
- Redirect penalty: a redirect sampled at edge N gives bubble on IF/ID after N, and the target instruction valid after N+1.
- halt_req at edge N: HALTED (halted=1) after edge N+DRAIN_CYCLES.
- `imem_addr` changes only after clock edges or reset.

## Structure
- Shared package `fetch_pkg` holds: NOP_INST=32'h0000_0013, the state enum {RUN, DRAIN, HALTED}, and the default RESET_PC. The control and hazard blocks reuse NOP_INST.
- Sub-module `if_id_reg` is the pipeline register: load/bubble/hold inputs, async reset to bubble.
- The PC register, FSM, drain counter and fetch counter stay in `fetch_stage`.

## Test plan
- Reset, release, no stall: imem_addr runs 0x0100_0000, 0x0100_0004, … The first valid IF/ID carries pc 0x0100_0000 one cycle after release. fetch_count=3 after 3 fetches.
- Stall held 2 cycles at PC 0x0100_0008: imem_addr, IF/ID and fetch_count are unchanged for both cycles, and resume +4 afterwards.
- Redirect to 0x0100_0040 together with stall: the next IF/ID is a bubble (0x13, valid=0), PC becomes 0x0100_0040, and the following IF/ID is valid with pc 0x0100_0040.
- Redirect to 0x0100_0042: PC becomes 0x0100_0040 and misaligned=1. The flag survives a later normal redirect.
- halt_req at edge N with redirect also high: redirect is ignored, bubbles for 4 cycles, halted=1 after N+4. Stall and redirect in HALTED have no effect.
- Reset asserted mid-DRAIN: outputs return to reset values immediately, and fetch resumes from 0x0100_0000 in RUN.
